frame_strobe_writer: RTL and testbench
======================================

Name: frame_strobe_writer

Overview:
- Configuration-side source of the per-column frame strobe / frame data bus that terminal tiles buffer and forward up the column.
- Accepts a stream of configuration words over a valid/ready handshake and assembles one frame of NumRows row words onto FrameData.
- Then pulses exactly one FrameStrobe bit for a fixed number of cycles, with a data hold cycle afterwards.
- One instance per fabric column, placed at the column's bottom edge below the south terminal tile.

Parameters:
- MaxFramesPerCol, 20, number of FrameStrobe lines per column.
- FrameBitsPerRow, 32, config word width and FrameData bits per row (must be >= 9).
- NumRows, 4, rows per column, and therefore data words per frame.
- StrobeCycles, 2, cycles FrameStrobe is held high (>= 1).

Ports:
- UserCLK  input  1  clock; all state is on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  block accepts a word; transfer when cfg_valid & cfg_ready at a rising edge.
- cfg_data  input  FrameBitsPerRow  header or data word.
- FrameData  output  NumRows*FrameBitsPerRow  row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  output  MaxFramesPerCol  one-hot or zero write strobe.
- frame_done  output  1  one-cycle pulse per completed frame write.
- frame_err  output  1  sticky flag: bad frame index received.
- err_clr  input  1  clears frame_err.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs low; FrameData=0; cfg_ready=0; row and strobe counters 0; any partial frame discarded; any active strobe drops immediately.
- First rising edge after resetn deasserts: cfg_ready <= 1.
- All outputs are registered except busy, which is decoded from the state register.
- States: IDLE, DATA, DROP, STROBE, HOLD. cfg_ready is 1 in IDLE/DATA/DROP and 0 in STROBE/HOLD; it is registered and tracks the next state.
- IDLE:
  - Accepted word with MSB=0: ignored, stay in IDLE.
  - Accepted word with MSB=1 is a header; idx = cfg_data[7:0].
  - idx < MaxFramesPerCol: latch idx, row_cnt=0, go to DATA.
  - Otherwise: set frame_err, row_cnt=0, go to DROP.
- DATA:
  - Each accepted word is written to FrameData row row_cnt; row_cnt increments. Row 0 is written first.
  - Rows not yet rewritten keep their previous values.
  - On accepting the word where row_cnt = NumRows-1 (call this edge T): go to STROBE, strobe_cnt=0.
  - Header marker is not checked in DATA; every word is treated as data.
- STROBE:
  - FrameStrobe[idx]=1 and all other bits 0, during cycles T+1 .. T+StrobeCycles.
  - FrameData is stable throughout.
  - Then go to HOLD.
- HOLD:
  - Single cycle at T+StrobeCycles+1: FrameStrobe=0, FrameData unchanged, frame_done=1.
  - Go to IDLE; cfg_ready is 1 from T+StrobeCycles+2.
- DROP: accept and discard NumRows words; FrameData and FrameStrobe are untouched; then go to IDLE. No frame_done.
- frame_err:
  - Set by an invalid header.
  - Cleared by err_clr when not being set in the same cycle; set wins if both occur together.
  - Does not block further operation.
- FrameData holds the last written frame indefinitely, until rows are overwritten or reset.
- cfg_valid low in DATA/DROP: block waits indefinitely with no timeout.
- Index width: idx compares as an unsigned 8-bit value. MaxFramesPerCol > 256 is unsupported.
- Throughput: one frame per NumRows+1+StrobeCycles+1 cycles at best.

Test Plan (defaults: NumRows=4, StrobeCycles=2):
- Normal frame:
  - Stimulus: header 0x8000_0005 then data 0x11111111, 0x22222222, 0x33333333, 0x44444444, back-to-back.
  - Required: FrameData = 0x44444444_33333333_22222222_11111111; FrameStrobe = 0x00020 for exactly 2 cycles starting the cycle after the last word; frame_done high 1 cycle later; cfg_ready low for 3 cycles.
- Invalid index:
  - Stimulus: header 0x8000_0014 (idx=20) plus 4 data words.
  - Required: frame_err=1; FrameStrobe stays 0; FrameData unchanged; no frame_done; the next valid frame proceeds normally.
- Backpressure / gaps:
  - Stimulus: cfg_valid toggled 1,0,0,1,... through the data phase; cfg_valid held high during STROBE/HOLD.
  - Required: no word is lost or duplicated; no transfer occurs while cfg_ready=0; the word held during STROBE is taken as the next header after HOLD.
- Non-header in IDLE:
  - Stimulus: 0x0000_0003, then header 0x8000_0000 plus 4 words.
  - Required: the first word is ignored; FrameStrobe[0] pulses once.
- Reset mid-operation:
  - Stimulus: assert resetn=0 during STROBE.
  - Required: FrameStrobe=0 and FrameData=0 immediately, without waiting for a clock edge; after release, cfg_ready rises on the first edge and a full frame works.
- Error clear race:
  - Stimulus: err_clr=1 in the same cycle an invalid header is accepted.
  - Required: frame_err=1. Then err_clr alone -> frame_err=0.

Source files
------------

// File: rtl/frame_strobe_writer_if.sv
// Configuration word stream feeding one column's frame strobe writer.
interface frame_strobe_writer_if #(
  parameter int FrameBitsPerRow = 32
);
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [FrameBitsPerRow-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/frame_strobe_writer.sv
// Assembles NumRows configuration words onto FrameData, then pulses one FrameStrobe line
// for StrobeCycles cycles followed by a single data-hold cycle.
module frame_strobe_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                                UserCLK,
  input  logic                                resetn,
  frame_strobe_writer_if.slave                cfg,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                frame_done,
  output logic                                frame_err,
  input  logic                                err_clr,
  output logic                                busy
);
  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int StbW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [RowW-1:0] LastRow  = RowW'(NumRows - 1);
  localparam logic [StbW-1:0] LastStb  = StbW'(StrobeCycles - 1);
  localparam logic [8:0]      IdxLimit = 9'(MaxFramesPerCol);

  typedef enum logic [2:0] {IDLE, DATA, DROP, STROBE, HOLD} state_t;

  state_t                                   state, state_next;
  logic [7:0]                               idx, idx_next;
  logic [RowW-1:0]                          row_cnt, row_cnt_next;
  logic [StbW-1:0]                          stb_cnt, stb_cnt_next;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]  rows, rows_next;
  logic [MaxFramesPerCol-1:0]               strobe_next;
  logic                                     done_next, err_set, err_next, ready_next;
  logic                                     accept, is_header, idx_ok;

  assign accept    = cfg.cfg_valid & cfg.cfg_ready;
  assign is_header = cfg.cfg_data[FrameBitsPerRow-1];
  assign idx_ok    = {1'b0, cfg.cfg_data[7:0]} < IdxLimit;
  assign busy      = (state != IDLE);
  assign FrameData = rows;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    row_cnt_next = row_cnt;
    stb_cnt_next = stb_cnt;
    rows_next    = rows;
    strobe_next  = FrameStrobe;
    done_next    = 1'b0;
    err_set      = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept && is_header) begin
          row_cnt_next = '0;
          if (idx_ok) begin
            idx_next   = cfg.cfg_data[7:0];
            state_next = DATA;
          end else begin
            err_set    = 1'b1;
            state_next = DROP;
          end
        end
      end
      DATA: begin
        if (accept) begin
          rows_next[row_cnt] = cfg.cfg_data;
          if (row_cnt == LastRow) begin
            state_next   = STROBE;
            stb_cnt_next = '0;
            strobe_next  = MaxFramesPerCol'(1) << idx;
          end else begin
            row_cnt_next = row_cnt + 1'b1;
          end
        end
      end
      DROP: begin
        // Words of a rejected frame are consumed so the stream stays aligned on headers.
        if (accept) begin
          if (row_cnt == LastRow) state_next = IDLE;
          else                    row_cnt_next = row_cnt + 1'b1;
        end
      end
      STROBE: begin
        if (stb_cnt == LastStb) begin
          state_next  = HOLD;
          strobe_next = '0;
          done_next   = 1'b1;
        end else begin
          stb_cnt_next = stb_cnt + 1'b1;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new error takes priority over a simultaneous clear.
  assign err_next   = err_set | (frame_err & ~err_clr);
  assign ready_next = (state_next == IDLE) || (state_next == DATA) || (state_next == DROP);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      idx           <= '0;
      row_cnt       <= '0;
      stb_cnt       <= '0;
      // NOTE: the row store is plain flops driving FrameData, so it clears on reset like any other state.
      rows          <= '0;
      FrameStrobe   <= '0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      cfg.cfg_ready <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      row_cnt       <= row_cnt_next;
      stb_cnt       <= stb_cnt_next;
      rows          <= rows_next;
      FrameStrobe   <= strobe_next;
      frame_done    <= done_next;
      frame_err     <= err_next;
      cfg.cfg_ready <= ready_next;
    end
  end
endmodule

// File: tb/tb_frame_strobe_writer.sv
// Directed and randomized checks of frame_strobe_writer against a word-stream reference model.
module tb_frame_strobe_writer;
  localparam int MaxF = 20;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int S    = 2;
  localparam int FDW  = N * W;

  logic            UserCLK = 1'b0;
  logic            resetn  = 1'b0;
  logic            err_clr = 1'b0;
  logic [FDW-1:0]  FrameData;
  logic [MaxF-1:0] FrameStrobe;
  logic            frame_done, frame_err, busy;

  frame_strobe_writer_if #(.FrameBitsPerRow(W)) cfg ();

  frame_strobe_writer #(
    .MaxFramesPerCol(MaxF), .FrameBitsPerRow(W), .NumRows(N), .StrobeCycles(S)
  ) dut (
    .UserCLK(UserCLK), .resetn(resetn), .cfg(cfg), .FrameData(FrameData),
    .FrameStrobe(FrameStrobe), .frame_done(frame_done), .frame_err(frame_err),
    .err_clr(err_clr), .busy(busy)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {logic [W-1:0] d; int k;} acc_t;
  typedef struct {int k; logic [MaxF-1:0] v; logic [FDW-1:0] fd;} stb_t;

  int n_cmp = 0;
  int n_bad = 0;
  int kneg  = 0;
  acc_t         acc_q[$];
  stb_t         stb_q[$];
  int           done_q[$];
  int           rdy_q[$];
  logic [W-1:0] stim_q[$];
  logic [N-1:0][W-1:0] exp_rows = '0;
  logic                exp_err  = 1'b0;

  // Observation log, indexed by falling-edge count; a transfer seen at negedge k lands on the next rising edge.
  always @(negedge UserCLK) begin
    if (resetn) begin
      if (cfg.cfg_valid && cfg.cfg_ready) acc_q.push_back('{d: cfg.cfg_data, k: kneg});
      if (FrameStrobe != '0) stb_q.push_back('{k: kneg, v: FrameStrobe, fd: FrameData});
      if (frame_done) done_q.push_back(kneg);
      if (!cfg.cfg_ready) rdy_q.push_back(kneg);
    end
    kneg <= kneg + 1;
  end

  task automatic chk(input string tag, input logic [FDW-1:0] obs, input logic [FDW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); stb_q.delete(); done_q.delete(); rdy_q.delete(); stim_q.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge UserCLK); #1; end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    logic got;
    got = 1'b0;
    cfg.cfg_valid = 1'b0;
    repeat (gap) begin @(posedge UserCLK); #1; end
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = w;
    stim_q.push_back(w);
    for (int t = 0; t < 100 && !got; t++) begin
      got = cfg.cfg_ready;
      @(posedge UserCLK); #1;
    end
    cfg.cfg_valid = 1'b0;
    chk("xfer_done", got, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] idx, input int max_gap);
    send_word({1'b1, 23'($urandom), idx}, 0);
    for (int r = 0; r < N; r++) send_word($urandom, $urandom_range(0, max_gap));
  endtask

  // Reference: walk the accepted word stream and derive strobe, done and ready-low cycles from the frame rules.
  task automatic check_stream(input string tag);
    stb_t         es[$];
    stb_t         e;
    int           ed[$];
    int           er[$];
    int           mode, got_rows, idx, win_end, k;
    logic [W-1:0] w;
    mode = 0; got_rows = 0; idx = 0; win_end = -1;
    chk({tag, "/n_words"}, acc_q.size(), stim_q.size());
    foreach (acc_q[i]) begin
      w = acc_q[i].d;
      k = acc_q[i].k;
      if (i < stim_q.size()) chk({tag, "/word"}, w, stim_q[i]);
      chk({tag, "/xfer_outside_strobe"}, (k > win_end), 1'b1);
      if (mode == 0) begin
        if (w[W-1]) begin
          got_rows = 0;
          if (w[7:0] < MaxF) begin idx = w[7:0]; mode = 1; end
          else begin exp_err = 1'b1; mode = 2; end
        end
      end else begin
        if (mode == 1) exp_rows[got_rows] = w;
        got_rows++;
        if (got_rows == N) begin
          if (mode == 1) begin
            for (int s = 1; s <= S; s++) begin
              e.k = k + s; e.v = MaxF'(1) << idx; e.fd = exp_rows;
              es.push_back(e);
            end
            ed.push_back(k + S + 1);
            for (int s = 1; s <= S + 1; s++) er.push_back(k + s);
            win_end = k + S + 1;
          end
          mode = 0;
        end
      end
    end
    chk({tag, "/n_strobe"}, stb_q.size(), es.size());
    foreach (es[i]) if (i < stb_q.size()) begin
      chk({tag, "/strobe_cycle"}, stb_q[i].k, es[i].k);
      chk({tag, "/strobe_value"}, stb_q[i].v, es[i].v);
      chk({tag, "/strobe_data"}, stb_q[i].fd, es[i].fd);
    end
    chk({tag, "/n_done"}, done_q.size(), ed.size());
    foreach (ed[i]) if (i < done_q.size()) chk({tag, "/done_cycle"}, done_q[i], ed[i]);
    chk({tag, "/n_ready_low"}, rdy_q.size(), er.size());
    foreach (er[i]) if (i < rdy_q.size()) chk({tag, "/ready_low_cycle"}, rdy_q[i], er[i]);
    chk({tag, "/frame_err"}, frame_err, exp_err);
    chk({tag, "/frame_data"}, FrameData, exp_rows);
    chk({tag, "/busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;

    // Reset values
    #12;
    chk("rst/frame_data", FrameData, '0);
    chk("rst/strobe", FrameStrobe, '0);
    chk("rst/ready", cfg.cfg_ready, 1'b0);
    chk("rst/done", frame_done, 1'b0);
    chk("rst/err", frame_err, 1'b0);
    chk("rst/busy", busy, 1'b0);
    @(negedge UserCLK); resetn = 1'b1;
    @(posedge UserCLK); #1;
    chk("rst/ready_first_edge", cfg.cfg_ready, 1'b1);
    clear_logs();

    // Normal frame, back-to-back
    send_word(32'h8000_0005, 0);
    chk("normal/busy", busy, 1'b1);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3333, 0);
    send_word(32'h4444_4444, 0);
    settle(6);
    chk("normal/frame_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    chk("normal/strobe_cycles", stb_q.size(), S);
    chk("normal/strobe_value", (stb_q.size() > 0) ? stb_q[0].v : 20'h0, 20'h00020);
    chk("normal/ready_low", rdy_q.size(), 3);
    chk("normal/done_delay", (done_q.size() > 0) ? done_q[0] - acc_q[$].k : -1, 3);
    check_stream("normal");
    clear_logs();

    // Invalid index, then a valid frame at the highest legal index
    send_word(32'h8000_0014, 0);
    for (int r = 0; r < N; r++) send_word($urandom, 1);
    settle(4);
    chk("invalid/no_strobe", stb_q.size(), 0);
    chk("invalid/no_done", done_q.size(), 0);
    chk("invalid/err", frame_err, 1'b1);
    send_frame(8'd19, 1);
    settle(6);
    check_stream("invalid");
    clear_logs();

    // Backpressure in data phase, next header held through STROBE/HOLD
    send_word(32'h8000_0001, 0);
    for (int r = 0; r < N; r++) send_word($urandom, 2);
    send_frame(8'd2, 0);
    settle(6);
    chk("bp/held_header_delay", (acc_q.size() > 5) ? acc_q[5].k - acc_q[4].k : -1, S + 2);
    check_stream("bp");
    clear_logs();

    // Non-header word in IDLE is ignored
    send_word(32'h0000_0003, 0);
    send_frame(8'd0, 0);
    settle(6);
    chk("nonhdr/strobe_cycles", stb_q.size(), S);
    chk("nonhdr/strobe_value", (stb_q.size() > 0) ? stb_q[0].v : 20'h0, 20'h00001);
    check_stream("nonhdr");
    clear_logs();

    // Error set/clear race
    err_clr = 1'b1; settle(1); err_clr = 1'b0; exp_err = 1'b0;
    chk("race/pre_clear", frame_err, 1'b0);
    cfg.cfg_valid = 1'b1; cfg.cfg_data = 32'h8000_0014; err_clr = 1'b1;
    stim_q.push_back(32'h8000_0014);
    @(posedge UserCLK); #1;
    cfg.cfg_valid = 1'b0; err_clr = 1'b0;
    chk("race/set_wins", frame_err, 1'b1);
    for (int r = 0; r < N; r++) send_word($urandom, 0);
    settle(4);
    check_stream("race");
    err_clr = 1'b1; settle(1); err_clr = 1'b0; exp_err = 1'b0;
    chk("race/cleared", frame_err, 1'b0);
    clear_logs();

    // Randomized stream
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10)      send_word({1'b0, 31'($urandom)}, $urandom_range(0, 2));
      else if (r < 25) send_frame(8'($urandom_range(20, 255)), 2);
      else             send_frame(8'($urandom_range(0, 19)), 2);
    end
    settle(6);
    check_stream("random");
    clear_logs();

    // Reset asserted during STROBE
    send_frame(8'd7, 0);
    chk("rst_mid/strobe_active", FrameStrobe, 20'h00080);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid/strobe", FrameStrobe, '0);
    chk("rst_mid/frame_data", FrameData, '0);
    chk("rst_mid/ready", cfg.cfg_ready, 1'b0);
    chk("rst_mid/busy", busy, 1'b0);
    chk("rst_mid/err", frame_err, 1'b0);
    exp_rows = '0;
    exp_err  = 1'b0;
    @(negedge UserCLK); resetn = 1'b1;
    @(posedge UserCLK); #1;
    chk("rst_mid/ready_first_edge", cfg.cfg_ready, 1'b1);
    clear_logs();
    send_frame(8'd17, 1);
    settle(6);
    check_stream("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
